// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and direction encodings, intended for reuse by Gray-pointer FIFO blocks.
package gray_counter_pkg;

  localparam int   MAX_WIDTH = 16;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above its position.
  function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
    logic [MAX_WIDTH-1:0] b;
    b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
    for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/gray2bin_conv.sv
// Combinational Gray-to-binary decoder of parameterised width.
module gray2bin_conv #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin[WIDTH-1] = i_gray[WIDTH-1];

  // Reduction form keeps every bit a direct function of the input (no ripple chain).
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_bit
      assign o_bin[gi] = ^i_gray[WIDTH-1:gi];
    end
  endgenerate

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray counter with a registered binary shadow, terminal-count flag and wrap pulse.
// Define GRAY_CNT_SAT_EN to saturate at the terminal count instead of wrapping.
module gray_counter_n
  import gray_counter_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] bin_out,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0]     RST_BIN       = WIDTH'(RST_VAL);
  localparam logic [MAX_WIDTH-1:0] RST_GRAY_FULL = bin2gray(MAX_WIDTH'(RST_BIN));
  localparam logic [WIDTH-1:0]     RST_GRAY      = RST_GRAY_FULL[WIDTH-1:0];
  localparam logic [WIDTH-1:0]     MAX_BIN       = '1;

  logic [WIDTH-1:0]     r_bin;
  logic [WIDTH-1:0]     r_gray;
  logic                 r_wrap;

  logic                 w_tc;
  logic [WIDTH-1:0]     w_step;
  logic [WIDTH-1:0]     w_bin_next;
  logic                 w_wrap_next;
  logic [MAX_WIDTH-1:0] w_gray_full;
  logic [WIDTH-1:0]     w_gray_next;

  assign w_tc   = (dir == DIR_UP) ? (r_bin == MAX_BIN) : (r_bin == '0);
  assign w_step = (dir == DIR_UP) ? (r_bin + 1'b1) : (r_bin - 1'b1);

  always_comb begin
    w_bin_next  = r_bin;
    w_wrap_next = 1'b0;
    if (load) begin
      w_bin_next = load_val;
    end else if (en) begin
`ifdef GRAY_CNT_SAT_EN
      if (!w_tc) begin
        w_bin_next = w_step;
      end
`else
      w_bin_next  = w_step;
      w_wrap_next = w_tc;
`endif
    end
  end

  // Gray register is encoded from the same next-state value so both registers stay in lockstep.
  assign w_gray_full = bin2gray(MAX_WIDTH'(w_bin_next));
  assign w_gray_next = w_gray_full[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin  <= RST_BIN;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_bin_next;
      r_gray <= w_gray_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign bin_out  = r_bin;
  assign gray_out = r_gray;
  assign wrap     = r_wrap;
  assign tc       = w_tc;

endmodule

// File: tb/tb_gray_counter_n.sv
// Directed and random checks of gray_counter_n at WIDTH 4, 3 and 8 (honours GRAY_CNT_SAT_EN).
`timescale 1ns/1ps
module tb_gray_counter_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       en4, dir4, load4, tc4, wrap4;
  logic [3:0] lv4, gray4, bin4;
  logic       en3, dir3, load3, tc3, wrap3;
  logic [2:0] lv3, gray3, bin3;
  logic       en8, dir8, load8, tc8, wrap8;
  logic [7:0] lv8, gray8, bin8, conv8;

  gray_counter_n #(.WIDTH(4), .RST_VAL(5)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .dir(dir4), .load(load4), .load_val(lv4),
    .gray_out(gray4), .bin_out(bin4), .tc(tc4), .wrap(wrap4));
  gray_counter_n #(.WIDTH(3), .RST_VAL(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .dir(dir3), .load(load3), .load_val(lv3),
    .gray_out(gray3), .bin_out(bin3), .tc(tc3), .wrap(wrap3));
  gray_counter_n #(.WIDTH(8), .RST_VAL(0)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .dir(dir8), .load(load8), .load_val(lv8),
    .gray_out(gray8), .bin_out(bin8), .tc(tc8), .wrap(wrap8));
  gray2bin_conv #(.WIDTH(8)) u_conv8 (.i_gray(gray8), .o_bin(conv8));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       load, en, dir;
    logic [3:0] lv;
    int         e_bin, e_gray, e_wrap, e_tc;
  } vec_t;

  function automatic vec_t mk(input string n, input logic l, input logic e, input logic d,
                              input logic [3:0] v, input int b, input int g, input int w,
                              input int t);
    vec_t r;
    r.name = n; r.load = l; r.en = e; r.dir = d; r.lv = v;
    r.e_bin = b; r.e_gray = g; r.e_wrap = w; r.e_tc = t;
    return r;
  endfunction

  task automatic step4(input logic l, input logic e, input logic d, input logic [3:0] v);
    @(negedge clk);
    load4 = l; en4 = e; dir4 = d; lv4 = v;
    @(posedge clk);
    #1;
  endtask

  task automatic step3(input logic l, input logic e, input logic d, input logic [2:0] v);
    @(negedge clk);
    load3 = l; en3 = e; dir3 = d; lv3 = v;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[8];
  int   gcode[16];

  initial begin
    int   exp_b, exp_w;
    logic [3:0] prev_g;
    int   m, nx, nw, tcv;
    logic [7:0] prev8;
    logic e, d, l;
    logic [7:0] v;

    gcode = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    vecs[0] = mk("load14",     1, 0, 0, 14, 14, 4'b1001, 0, 0);
    vecs[1] = mk("up_to15",    0, 1, 0,  0, 15, 4'b1000, 0, 1);
    vecs[2] = mk("load_prio",  1, 1, 0, 10, 10, 4'b1111, 0, 0);
    vecs[3] = mk("load15",     1, 0, 0, 15, 15, 4'b1000, 0, 1);
`ifdef GRAY_CNT_SAT_EN
    vecs[4] = mk("up_at_max",  0, 1, 0,  0, 15, 4'b1000, 0, 1);
    vecs[5] = mk("hold_dn",    0, 0, 1,  0, 15, 4'b1000, 0, 0);
    vecs[6] = mk("down_step",  0, 1, 1,  0, 14, 4'b1001, 0, 0);
    vecs[7] = mk("dir_flip",   0, 1, 0,  0, 15, 4'b1000, 0, 1);
`else
    vecs[4] = mk("up_wrap",    0, 1, 0,  0,  0, 4'b0000, 1, 0);
    vecs[5] = mk("hold_dn",    0, 0, 1,  0,  0, 4'b0000, 0, 1);
    vecs[6] = mk("down_wrap",  0, 1, 1,  0, 15, 4'b1000, 1, 0);
    vecs[7] = mk("dir_flip",   0, 1, 0,  0,  0, 4'b0000, 1, 0);
`endif

    rst_n = 1'b0;
    {en4, dir4, load4, lv4} = '0;
    {en3, dir3, load3, lv3} = '0;
    {en8, dir8, load8, lv8} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_bin4",  bin4,  5);
    chk("rst_gray4", gray4, 4'b0111);
    chk("rst_wrap4", wrap4, 0);
    chk("rst_tc4",   tc4,   0);
    chk("rst_bin3",  bin3,  0);
    chk("rst_bin8",  bin8,  0);
    $display("reset: bin4=%0d gray4=%b", bin4, gray4);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      step4(vecs[i].load, vecs[i].en, vecs[i].dir, vecs[i].lv);
      chk({vecs[i].name, "_bin"},  bin4,  vecs[i].e_bin);
      chk({vecs[i].name, "_gray"}, gray4, vecs[i].e_gray);
      chk({vecs[i].name, "_wrap"}, wrap4, vecs[i].e_wrap);
      chk({vecs[i].name, "_tc"},   tc4,   vecs[i].e_tc);
      $display("vec %s: load=%b en=%b dir=%b -> bin=%0d gray=%b wrap=%b tc=%b",
               vecs[i].name, vecs[i].load, vecs[i].en, vecs[i].dir, bin4, gray4, wrap4, tc4);
    end

    // Seventeen up-steps from zero across the 15 -> 0 boundary.
    step4(1, 0, 0, 0);
    chk("seq_start", bin4, 0);
    prev_g = gray4;
    for (int k = 1; k <= 17; k++) begin
      step4(0, 1, 0, 0);
`ifdef GRAY_CNT_SAT_EN
      exp_b = (k > 15) ? 15 : k;
      exp_w = 0;
`else
      exp_b = k % 16;
      exp_w = (k == 16) ? 1 : 0;
`endif
      chk($sformatf("upseq%0d_bin", k),  bin4,  exp_b);
      chk($sformatf("upseq%0d_gray", k), gray4, gcode[exp_b]);
      chk($sformatf("upseq%0d_wrap", k), wrap4, exp_w);
      chk($sformatf("upseq%0d_1bit", k), $countones(prev_g ^ gray4), (k > 15 && exp_b == 15) ? 0 : 1);
      $display("upseq %0d: bin=%0d gray=%b wrap=%b", k, bin4, gray4, wrap4);
      prev_g = gray4;
    end

`ifdef GRAY_CNT_SAT_EN
    for (int k = 0; k < 3; k++) begin
      step4(0, 1, 0, 0);
      chk("sat_bin",  bin4,  15);
      chk("sat_tc",   tc4,   1);
      chk("sat_wrap", wrap4, 0);
      $display("sat %0d: bin=%0d tc=%b", k, bin4, tc4);
    end
    step4(0, 1, 1, 0);
    chk("sat_down_bin", bin4, 14);
    $display("sat down: bin=%0d", bin4);
`endif

    // Asynchronous reset while a load is being presented, between clock edges.
    step4(1, 0, 0, 2);
    step4(0, 1, 0, 0);
    chk("pre_rst_bin", bin4, 3);
    @(negedge clk);
    load4 = 1'b1; lv4 = 4'd9; en4 = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_bin",  bin4,  5);
    chk("arst_gray", gray4, 4'b0111);
    chk("arst_wrap", wrap4, 0);
    $display("async reset: bin4=%0d gray4=%b", bin4, gray4);
    @(negedge clk);
    load4 = 1'b0; en4 = 1'b0; dir4 = 1'b0;
    rst_n = 1'b1;
    step4(0, 0, 0, 0);
    chk("post_rst_hold", bin4, 5);
    step4(0, 1, 0, 0);
    chk("post_rst_bin",  bin4,  6);
    chk("post_rst_gray", gray4, 4'b0101);
    $display("post reset step: bin4=%0d gray4=%b", bin4, gray4);

    // Down from zero at WIDTH=3.
    @(negedge clk);
    dir3 = 1'b1;
    #1;
    chk("dn3_tc_pre", tc3, 1);
    step3(0, 1, 1, 0);
`ifdef GRAY_CNT_SAT_EN
    chk("dn3_bin",  bin3,  0);
    chk("dn3_gray", gray3, 0);
    chk("dn3_wrap", wrap3, 0);
`else
    chk("dn3_bin",  bin3,  7);
    chk("dn3_gray", gray3, 3'b100);
    chk("dn3_wrap", wrap3, 1);
`endif
    $display("down3: bin=%0d gray=%b wrap=%b", bin3, gray3, wrap3);
    step3(0, 0, 1, 0);
    chk("dn3_wrap_clr", wrap3, 0);
    $display("down3 hold: bin=%0d wrap=%b", bin3, wrap3);

    // Random stimulus at WIDTH=8 against a behavioural model.
    m = 0;
    prev8 = gray8;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      e = 1'($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 7) == 0);
      v = 8'($urandom_range(0, 255));
      en8 = e; dir8 = d; load8 = l; lv8 = v;
      nx = m; nw = 0;
      tcv = d ? (m == 0) : (m == 255);
      if (l) begin
        nx = v;
      end else if (e) begin
`ifdef GRAY_CNT_SAT_EN
        if (tcv == 0) nx = d ? m - 1 : m + 1;
`else
        nx = d ? (m + 255) % 256 : (m + 1) % 256;
        nw = tcv;
`endif
      end
      @(posedge clk);
      #1;
      chk("rnd_bin",  bin8,  nx);
      chk("rnd_gray", gray8, nx ^ (nx >> 1));
      chk("rnd_wrap", wrap8, nw);
      chk("rnd_conv", conv8, bin8);
      chk("rnd_tc",   tc8,   d ? (nx == 0) : (nx == 255));
      if (!l && nx != m) chk("rnd_1bit", $countones(prev8 ^ gray8), 1);
      m = nx;
      prev8 = gray8;
      if (c % 1000 == 999) $display("random %0d: bin8=%0d gray8=%h", c + 1, bin8, gray8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_counter_n.md
GRAY_COUNTER_N -- requirements
Module: gray_counter_n

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..16.
REQ-002 Parameter: RST_VAL, default 0, binary reset value; must be < 2**WIDTH.
REQ-003 Port: clk  input  1  sole clock, all state on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: en  input  1  count enable.
REQ-006 Port: dir  input  1  direction: 0 = up, 1 = down.
REQ-007 Port: load  input  1  synchronous load strobe.
REQ-008 Port: load_val  input  WIDTH  binary value to load.
REQ-009 Port: gray_out  output  WIDTH  registered Gray-coded count.
REQ-010 Port: bin_out  output  WIDTH  registered binary count, always equal to the Gray-decode of gray_out.
REQ-011 Port: tc  output  1  combinational terminal-count flag.
REQ-012 Port: wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-013 State: binary register bin_q plus Gray register gray_q; gray_q SHALL equal bin_q ^ (bin_q >> 1) at every clock edge and at reset.
REQ-014 Priority per edge: load > en > hold.
REQ-015 load=1: bin_q <= load_val and gray_q <= its Gray code, regardless of en and dir; wrap <= 0.
REQ-016 load=0, en=1, dir=0: bin_q <= bin_q + 1, modulo 2**WIDTH.
REQ-017 load=0, en=1, dir=1: bin_q <= bin_q - 1, modulo 2**WIDTH.
REQ-018 en=0 and load=0: all registers hold; wrap <= 0.
REQ-019 Latency: gray_out and bin_out reflect a step or load on the edge that samples the control; there is no extra pipeline stage.
REQ-020 Each counting step SHALL change exactly one bit of gray_out, including at the wrap boundaries.
REQ-021 tc = 1 when dir=0 and bin_q = 2**WIDTH-1, or when dir=1 and bin_q = 0; tc is independent of en.
REQ-022 wrap SHALL be 1 for exactly one cycle after an enabled step in which tc was 1 and load was 0; otherwise 0.
REQ-023 A dir change takes effect on the same edge; no dead cycle.

Reset
REQ-024 While rst_n=0: bin_q = RST_VAL, gray_q = Gray(RST_VAL), wrap = 0.
REQ-025 Reset assertion SHALL take effect immediately without a clock edge, including mid-count and during load.
REQ-026 First step after rst_n deasserts SHALL occur on the first rising edge with en=1 or load=1.

Configuration
REQ-027 Macro: GRAY_CNT_SAT_EN.
REQ-028 Macro defined: counter saturates instead of wrapping. With en=1 and tc=1, bin_q holds. wrap SHALL stay 0. load still overrides.
REQ-029 Macro undefined: modulo wrap per REQ-016/017 and wrap pulse per REQ-022.

Structure
REQ-030 Package: gray_counter_pkg holds DIR_UP/DIR_DOWN localparams and bin2gray/gray2bin functions, shared with future Gray-pointer FIFO blocks.
REQ-031 Sub-module: gray2bin_conv, a combinational Gray-to-binary decoder with parameter WIDTH, used by the bench checker and optional inside RTL.
REQ-032 There SHALL be no latches, and every combinational block SHALL assign a default value.

Verification
REQ-033 Reset: WIDTH=4, RST_VAL=5, pull rst_n low mid-count between edges -> bin_out=5, gray_out=4'b0111, wrap=0, with no clock edge needed.
REQ-034 Up wrap: WIDTH=4, en=1, dir=0, run from 0 for 17 cycles -> gray_out sequence 0,1,3,2,6,…,8,0,1; wrap high for exactly the cycle after 15->0; single-bit change at every step.
REQ-035 Down wrap: WIDTH=3, dir=1, start at 0 -> next bin_out=7, gray_out=3'b100, wrap=1 for one cycle.
REQ-036 Load priority: en=1, dir=0, load=1, load_val=10 at bin_q=15 -> bin_out=10, gray_out=4'b1111, wrap=0.
REQ-037 Saturation (GRAY_CNT_SAT_EN defined): at bin_q=15 with en=1, dir=0 for 3 cycles -> bin_out stays 15, tc=1, wrap=0; dir=1 on the next cycle -> bin_out=14.
REQ-038 Random: 10k cycles of random en/dir/load with WIDTH=8 -> bin_out equals gray2bin_conv(gray_out) every cycle and matches the reference model.
